// File: rtl/decode_stage_pkg.sv
// Shared types, widths and the RV64 base-ISA instruction decoder for decode_stage.
package decode_stage_pkg;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned NREG     = 32;
   localparam int unsigned DEF_NFWD = 2;
   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned RADDR_W  = 5;

   typedef logic [XLEN-1:0]    word_t;
   typedef logic [RADDR_W-1:0] creg_addr_t;
   typedef logic [63:0]        u64;

   typedef enum logic [3:0] {
      OPC_ILLEGAL,
      OPC_ALU,
      OPC_ALUI,
      OPC_LOAD,
      OPC_STORE,
      OPC_BRANCH,
      OPC_LUI,
      OPC_AUIPC,
      OPC_JAL,
      OPC_JALR
   } op_class_e;

   typedef struct packed {
      op_class_e  op;
      logic [2:0] funct3;
      logic       alt;
      logic       word;
      logic       use_rs1;
      logic       use_rs2;
      logic       wb_en;
   } ctl_t;

   typedef struct packed {
      word_t               pc;
      logic [INSTR_W-1:0]  raw_instr;
      ctl_t                ctl;
      creg_addr_t          dst;
      word_t               srca;
      word_t               srcb;
      word_t               imm;
   } decode_data_t;

   typedef struct packed {
      logic       valid;
      logic       pending;
      creg_addr_t addr;
      word_t      data;
   } fwd_src_t;

   typedef struct packed {
      ctl_t       ctl;
      creg_addr_t rd;
      creg_addr_t rs1;
      creg_addr_t rs2;
      word_t      imm;
   } decoded_t;

   // Field extraction and sign-extended immediate per RV64I opcode.
   function automatic decoded_t decode_instr(input logic [INSTR_W-1:0] ins);
      decoded_t d;
      word_t    imm_i, imm_s, imm_b, imm_u, imm_j;
      imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
      imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      imm_u = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
      imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      d            = '0;
      d.rd         = ins[11:7];
      d.rs1        = ins[19:15];
      d.rs2        = ins[24:20];
      d.ctl.funct3 = ins[14:12];
      d.ctl.alt    = ins[30];
      d.ctl.op     = OPC_ILLEGAL;
      case (ins[6:0])
         7'b0110011, 7'b0111011: begin
            d.ctl.op = OPC_ALU;    d.ctl.use_rs1 = 1'b1; d.ctl.use_rs2 = 1'b1;
            d.ctl.wb_en = 1'b1;    d.ctl.word = ins[3];
         end
         7'b0010011, 7'b0011011: begin
            d.ctl.op = OPC_ALUI;   d.ctl.use_rs1 = 1'b1; d.ctl.wb_en = 1'b1;
            d.ctl.word = ins[3];   d.imm = imm_i;
         end
         7'b0000011: begin
            d.ctl.op = OPC_LOAD;   d.ctl.use_rs1 = 1'b1; d.ctl.wb_en = 1'b1; d.imm = imm_i;
         end
         7'b0100011: begin
            d.ctl.op = OPC_STORE;  d.ctl.use_rs1 = 1'b1; d.ctl.use_rs2 = 1'b1; d.imm = imm_s;
         end
         7'b1100011: begin
            d.ctl.op = OPC_BRANCH; d.ctl.use_rs1 = 1'b1; d.ctl.use_rs2 = 1'b1; d.imm = imm_b;
         end
         7'b0110111: begin
            d.ctl.op = OPC_LUI;    d.ctl.wb_en = 1'b1; d.imm = imm_u;
         end
         7'b0010111: begin
            d.ctl.op = OPC_AUIPC;  d.ctl.wb_en = 1'b1; d.imm = imm_u;
         end
         7'b1101111: begin
            d.ctl.op = OPC_JAL;    d.ctl.wb_en = 1'b1; d.imm = imm_j;
         end
         7'b1100111: begin
            d.ctl.op = OPC_JALR;   d.ctl.use_rs1 = 1'b1; d.ctl.wb_en = 1'b1; d.imm = imm_i;
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of decode_stage (slave = the stage).
interface decode_stage_if;
   import decode_stage_pkg::*;

   logic               in_valid;
   logic               in_ready;
   word_t              in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   decode_data_t       out_data;

   modport slave (
      input  in_valid, in_pc, in_instr, flush, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_pc, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_data
   );

endinterface

// File: rtl/decode_stage_hazard_unit.sv
// decode_hazard_unit: combinational operand resolution and load-use hazard detection.
// DECODE_BYPASS_EN adds the writeback write-through path below the forwarding sources.
module decode_hazard_unit
   import decode_stage_pkg::*;
#(
   parameter int unsigned NSRC = DEF_NFWD
) (
   input  logic                 valid_i,
   input  logic                 use_rs1_i,
   input  logic                 use_rs2_i,
   input  creg_addr_t           rs1_i,
   input  creg_addr_t           rs2_i,
   input  fwd_src_t [NSRC-1:0]  fwd_i,
`ifdef DECODE_BYPASS_EN
   input  logic                 wen_i,
   input  creg_addr_t           wa_i,
   input  word_t                wd_i,
`endif
   input  word_t                rf_rs1_i,
   input  word_t                rf_rs2_i,
   output word_t                srca_c_o,
   output word_t                srcb_c_o,
   output logic                 hazard_c_o
);

   typedef struct packed {
      word_t value;
      logic  pending;
   } operand_t;

   operand_t op_a, op_b;

   // Youngest matching source wins; it blocks only if its value is still pending.
   function automatic operand_t resolve(input creg_addr_t rs, input word_t rf_val);
      operand_t r;
      r.pending = 1'b0;
`ifdef DECODE_BYPASS_EN
      r.value = (wen_i && (wa_i == rs)) ? wd_i : rf_val;
`else
      r.value = rf_val;
`endif
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (fwd_i[i].valid && (fwd_i[i].addr == rs)) begin
            r.value   = fwd_i[i].data;
            r.pending = fwd_i[i].pending;
         end
      end
      if (rs == '0) begin
         r.value   = '0;
         r.pending = 1'b0;
      end
      return r;
   endfunction

   always_comb begin
      op_a       = resolve(rs1_i, rf_rs1_i);
      op_b       = resolve(rs2_i, rf_rs2_i);
      srca_c_o   = use_rs1_i ? op_a.value : '0;
      srcb_c_o   = use_rs2_i ? op_b.value : '0;
      hazard_c_o = valid_i && ((use_rs1_i && op_a.pending) || (use_rs2_i && op_b.pending));
   end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decoder, regfile, operand forwarding, pipe register, stall counter.
// DECODE_BYPASS_EN enables the writeback write-through bypass in operand selection.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned NFWD = DEF_NFWD
) (
   input  logic                      clk,
   input  logic                      reset,
   decode_stage_if.slave             pipe,
   input  logic       [NFWD-1:0]     fwd_valid,
   input  logic       [NFWD-1:0]     fwd_pending,
   input  creg_addr_t [NFWD-1:0]     fwd_addr,
   input  word_t      [NFWD-1:0]     fwd_data,
   input  logic                      wen,
   input  creg_addr_t                wa,
   input  word_t                     wd,
   output logic       [31:0]         stall_cnt,
   output word_t      [NREG-1:0]     next_reg
);

   word_t [NREG-1:0]     rf_q, rf_d;
   decoded_t             dec;
   fwd_src_t [NFWD-1:0]  fwd;
   word_t                srca, srcb;
   logic                 hazard;
   logic                 accept;
   logic                 out_valid_q, out_valid_d;
   decode_data_t         out_data_q, out_data_d;
   logic [31:0]          stall_cnt_q, stall_cnt_d;

   assign dec = decode_instr(pipe.in_instr);

   for (genvar g = 0; g < NFWD; g++) begin : g_fwd
      assign fwd[g] = '{valid: fwd_valid[g], pending: fwd_pending[g],
                        addr: fwd_addr[g], data: fwd_data[g]};
   end

   decode_hazard_unit #(
      .NSRC (NFWD)
   ) u_hazard (
      .valid_i    (pipe.in_valid),
      .use_rs1_i  (dec.ctl.use_rs1),
      .use_rs2_i  (dec.ctl.use_rs2),
      .rs1_i      (dec.rs1),
      .rs2_i      (dec.rs2),
      .fwd_i      (fwd),
`ifdef DECODE_BYPASS_EN
      .wen_i      (wen),
      .wa_i       (wa),
      .wd_i       (wd),
`endif
      .rf_rs1_i   (rf_q[dec.rs1]),
      .rf_rs2_i   (rf_q[dec.rs2]),
      .srca_c_o   (srca),
      .srcb_c_o   (srcb),
      .hazard_c_o (hazard)
   );

   assign pipe.in_ready  = !reset && (!out_valid_q || pipe.out_ready) && !hazard && !pipe.flush;
   assign accept         = pipe.in_valid && pipe.in_ready;
   assign pipe.out_valid = out_valid_q;
   assign pipe.out_data  = out_data_q;
   assign stall_cnt      = stall_cnt_q;
   assign next_reg       = rf_d;

   // Pipe register next state: flush > accept > drain > hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (pipe.flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d          = 1'b1;
         out_data_d.pc        = pipe.in_pc;
         out_data_d.raw_instr = pipe.in_instr;
         out_data_d.ctl       = dec.ctl;
         out_data_d.dst       = dec.ctl.wb_en ? dec.rd : '0;
         out_data_d.srca      = srca;
         out_data_d.srcb      = srcb;
         out_data_d.imm       = dec.imm;
      end else if (pipe.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard && !pipe.flush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Regfile next state doubles as the difftest view; x0 is never written.
   always_comb begin
      rf_d = rf_q;
      if (wen && (wa != '0)) begin
         rf_d[wa] = wd;
      end
      if (reset) begin
         rf_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         stall_cnt_q <= '0;
         rf_q        <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         stall_cnt_q <= stall_cnt_d;
         rf_q        <= rf_d;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then randomized traffic
// against a behavioural model of decode, forwarding, hazards and the regfile.
module tb_decode_stage;
   import decode_stage_pkg::*;

   localparam int unsigned NF = DEF_NFWD;
   localparam int K_ADD = 0, K_ADDI = 1, K_LUI = 2, K_SW = 3, K_BEQ = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic       [NF-1:0]   fwd_valid, fwd_pending;
   creg_addr_t [NF-1:0]   fwd_addr;
   word_t      [NF-1:0]   fwd_data;
   logic                  wen;
   creg_addr_t            wa;
   word_t                 wd;
   logic [31:0]           stall_cnt;
   word_t [NREG-1:0]      next_reg;

   decode_stage_if dif ();

   decode_stage #(.NFWD(NF)) dut (
      .clk         (clk),
      .reset       (reset),
      .pipe        (dif),
      .fwd_valid   (fwd_valid),
      .fwd_pending (fwd_pending),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data),
      .wen         (wen),
      .wa          (wa),
      .wd          (wd),
      .stall_cnt   (stall_cnt),
      .next_reg    (next_reg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input u64 got, input u64 exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference state
   u64         m_rf [NREG];
   logic       m_valid;
   u64         m_pc, m_raw, m_dst, m_srca, m_srcb, m_imm, m_flags, m_stall;
   // Meaning of the instruction currently offered by fetch
   creg_addr_t c_rd, c_rs1, c_rs2;
   logic       c_use1, c_use2, c_wb;
   u64         c_imm;
   logic       last_acc;

   task automatic set_instr(input int kind, input creg_addr_t rd, input creg_addr_t rs1,
                            input creg_addr_t rs2, input int imm);
      logic [31:0] v;
      logic [31:0] ins;
      v = 32'(imm);
      c_use1 = 1'b0; c_use2 = 1'b0; c_wb = 1'b0;
      c_imm  = u64'(longint'(imm));
      ins    = '0;
      case (kind)
         K_ADD:  begin ins = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
                       c_use1 = 1'b1; c_use2 = 1'b1; c_wb = 1'b1; c_imm = '0; end
         K_ADDI: begin ins = {v[11:0], rs1, 3'b000, rd, 7'b0010011};
                       c_use1 = 1'b1; c_wb = 1'b1; end
         K_LUI:  begin ins = {v[19:0], rd, 7'b0110111};
                       c_wb = 1'b1; c_imm = u64'(longint'(imm) * 64'sd4096); end
         K_SW:   begin ins = {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
                       c_use1 = 1'b1; c_use2 = 1'b1; end
         default: begin ins = {v[12], v[10:5], rs2, rs1, 3'b000, v[4:1], v[11], 7'b1100011};
                       c_use1 = 1'b1; c_use2 = 1'b1; end
      endcase
      dif.in_instr = ins;
      c_rd = rd; c_rs1 = rs1; c_rs2 = rs2;
   endtask

   function automatic int first_fwd(input creg_addr_t rs);
      for (int i = 0; i < int'(NF); i++)
         if (fwd_valid[i] && fwd_addr[i] == rs) return i;
      return -1;
   endfunction

   function automatic u64 operand(input creg_addr_t rs);
      int k;
      if (rs == '0) return '0;
      k = first_fwd(rs);
      if (k >= 0) return fwd_data[k];
`ifdef DECODE_BYPASS_EN
      if (wen && wa == rs) return wd;
`endif
      return m_rf[rs];
   endfunction

   function automatic logic blocked(input logic use_rs, input creg_addr_t rs);
      int k;
      if (!use_rs || rs == '0) return 1'b0;
      k = first_fwd(rs);
      return (k >= 0) && fwd_pending[k];
   endfunction

   function automatic u64 exp_next(input creg_addr_t k);
      if (reset) return '0;
      if (wen && wa == k && k != '0) return wd;
      return m_rf[k];
   endfunction

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic cycle();
      logic       haz, rdy, acc;
      creg_addr_t k;
      #1;
      haz = dif.in_valid && (blocked(c_use1, c_rs1) || blocked(c_use2, c_rs2));
      rdy = !reset && (!m_valid || dif.out_ready) && !haz && !dif.flush;
      acc = dif.in_valid && rdy;
      check("in_ready", u64'(dif.in_ready), u64'(rdy));
      k = creg_addr_t'($urandom_range(0, NREG - 1));
      check("next_reg_rand", next_reg[k], exp_next(k));
      if (wen) check("next_reg_wa", next_reg[wa], exp_next(wa));
      last_acc = acc;
      if (reset) begin
         foreach (m_rf[i]) m_rf[i] = '0;
         m_valid = 1'b0; m_stall = '0;
         m_pc = '0; m_raw = '0; m_dst = '0; m_srca = '0; m_srcb = '0; m_imm = '0; m_flags = '0;
      end else begin
         if (dif.flush) m_valid = 1'b0;
         else if (acc) begin
            m_valid = 1'b1;
            m_pc    = dif.in_pc;
            m_raw   = u64'(dif.in_instr);
            m_dst   = c_wb ? u64'(c_rd) : '0;
            m_srca  = c_use1 ? operand(c_rs1) : '0;
            m_srcb  = c_use2 ? operand(c_rs2) : '0;
            m_imm   = c_imm;
            m_flags = u64'({c_use1, c_use2, c_wb});
         end else if (dif.out_ready) m_valid = 1'b0;
         if (haz && !dif.flush && m_stall != 64'hFFFF_FFFF) m_stall++;
         if (wen && wa != '0) m_rf[wa] = wd;
      end
      @(posedge clk);
      @(negedge clk);
      check("out_valid", u64'(dif.out_valid), u64'(m_valid));
      check("stall_cnt", u64'(stall_cnt), m_stall);
      if (m_valid) begin
         check("pc",    dif.out_data.pc, m_pc);
         check("raw",   u64'(dif.out_data.raw_instr), m_raw);
         check("dst",   u64'(dif.out_data.dst), m_dst);
         check("srca",  dif.out_data.srca, m_srca);
         check("srcb",  dif.out_data.srcb, m_srcb);
         check("imm",   dif.out_data.imm, m_imm);
         check("flags", u64'({dif.out_data.ctl.use_rs1, dif.out_data.ctl.use_rs2,
                              dif.out_data.ctl.wb_en}), m_flags);
      end
   endtask

   task automatic random_instr();
      int kind, imm;
      kind = int'($urandom_range(0, 4));
      case (kind)
         K_LUI:   imm = int'($urandom_range(0, 1048575)) - 524288;
         K_BEQ:   imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
         default: imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      set_instr(kind, creg_addr_t'($urandom_range(0, 7)), creg_addr_t'($urandom_range(0, 7)),
                creg_addr_t'($urandom_range(0, 7)), imm);
   endtask

   initial begin
      logic hold;
      reset = 1'b1;
      dif.in_valid = 1'b0; dif.in_pc = '0; dif.flush = 1'b0; dif.out_ready = 1'b1;
      fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0;
      wen = 1'b0; wa = '0; wd = '0;
      m_valid = 1'b0; m_stall = '0;
      foreach (m_rf[i]) m_rf[i] = '0;
      set_instr(K_ADDI, 5'd0, 5'd0, 5'd0, 0);

      // Reset state
      cycle(); cycle();
      check("rst_out_data", u64'(|dif.out_data), '0);
      check("rst_next_reg", u64'(|next_reg), '0);
      check("rst_in_ready", u64'(dif.in_ready), '0);
      reset = 1'b0;

      // addi x1,x0,5
      set_instr(K_ADDI, 5'd1, 5'd0, 5'd0, 5);
      dif.in_valid = 1'b1; dif.in_pc = 64'h1000;
      cycle();
      check("addi_valid", u64'(dif.out_valid), 64'd1);
      check("addi_imm", dif.out_data.imm, 64'd5);
      check("addi_dst", u64'(dif.out_data.dst), 64'd1);
      check("addi_srca", dif.out_data.srca, 64'd0);

      // Youngest forwarding source wins
      fwd_valid = 2'b11; fwd_addr[0] = 5'd3; fwd_addr[1] = 5'd3;
      fwd_data[0] = 64'hAA; fwd_data[1] = 64'hBB;
      set_instr(K_ADD, 5'd4, 5'd3, 5'd3, 0);
      dif.in_pc = 64'h1004;
      cycle();
      check("fwd_srca", dif.out_data.srca, 64'hAA);
      check("fwd_srcb", dif.out_data.srcb, 64'hAA);

      // Load-use stall on x5 for three cycles, then release
      fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_addr[0] = 5'd5; fwd_data[0] = 64'h55;
      set_instr(K_ADD, 5'd6, 5'd5, 5'd0, 0);
      dif.in_pc = 64'h1008;
      repeat (3) begin
         cycle();
         check("stall_in_ready", u64'(dif.in_ready), '0);
         check("stall_out_valid", u64'(dif.out_valid), '0);
      end
      check("stall_cnt3", u64'(stall_cnt), 64'd3);
      fwd_pending = '0;
      cycle();
      check("release_valid", u64'(dif.out_valid), 64'd1);
      check("release_srca", dif.out_data.srca, 64'h55);
      fwd_valid = '0;

      // Backpressure holds the register, then flush empties it
      dif.out_ready = 1'b0;
      set_instr(K_ADDI, 5'd9, 5'd0, 5'd0, 7);
      dif.in_pc = 64'h100C;
      cycle();
      check("bp_pc", dif.out_data.pc, 64'h1008);
      check("bp_in_ready", u64'(dif.in_ready), '0);
      dif.flush = 1'b1;
      cycle();
      check("flush_valid", u64'(dif.out_valid), '0);
      dif.flush = 1'b0; dif.out_ready = 1'b1; dif.in_valid = 1'b0;

      // Writeback to x7 in the same cycle as a read of x7
      wen = 1'b1; wa = 5'd7; wd = 64'h1234;
      set_instr(K_ADD, 5'd8, 5'd7, 5'd0, 0);
      dif.in_valid = 1'b1; dif.in_pc = 64'h1010;
      cycle();
`ifdef DECODE_BYPASS_EN
      check("wb_bypass_srca", dif.out_data.srca, 64'h1234);
`else
      check("wb_nobypass_srca", dif.out_data.srca, 64'h0);
`endif
      wen = 1'b0; dif.in_valid = 1'b0;
      cycle();

      // Randomized traffic, with one reset pulse mid-run
      hold = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if (!hold) begin
            dif.in_valid = ($urandom_range(0, 3) != 0);
            dif.in_pc    = {$urandom, $urandom};
            random_instr();
         end
         dif.out_ready = ($urandom_range(0, 3) != 0);
         dif.flush     = ($urandom_range(0, 19) == 0);
         reset         = (n == 700);
         for (int i = 0; i < int'(NF); i++) begin
            fwd_valid[i]   = $urandom_range(0, 1) != 0;
            fwd_pending[i] = $urandom_range(0, 3) == 0;
            fwd_addr[i]    = creg_addr_t'($urandom_range(0, 7));
            fwd_data[i]    = {$urandom, $urandom};
         end
         wen = $urandom_range(0, 1) != 0;
         wa  = creg_addr_t'($urandom_range(0, 7));
         wd  = {$urandom, $urandom};
         cycle();
         hold = dif.in_valid && !last_acc && !dif.flush && !reset;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
